// File: rtl/axis_async_fifo.sv
// Dual-clock AXI-Stream FIFO: gray-coded pointers cross the clock domains and a
// first-word-fall-through output register feeds the reader. Fill levels are conservative.
module axis_async_fifo #(
    parameter int DEPTH       = 16,
    parameter int DATA_W      = 8,
    parameter int SYNC_STAGES = 2,
    parameter int AFULL_LVL   = DEPTH - 2,
    parameter int AEMPTY_LVL  = 2
) (
    input  logic                   i_wclk,
    input  logic                   i_rst_n,
    input  logic                   i_rclk,
    input  logic                   s_tvalid,
    output logic                   s_tready,
    input  logic [DATA_W-1:0]      s_tdata,
    input  logic                   s_tlast,
    output logic [$clog2(DEPTH):0] o_wcount,
    output logic                   o_walmost_full,
    output logic                   m_tvalid,
    input  logic                   m_tready,
    output logic [DATA_W-1:0]      m_tdata,
    output logic                   m_tlast,
    output logic [$clog2(DEPTH):0] o_rcount,
    output logic                   o_ralmost_empty
);
    localparam int AW = $clog2(DEPTH);
    typedef logic [AW:0] ptr_t;
    localparam ptr_t AFULL_P  = ptr_t'(AFULL_LVL);
    localparam ptr_t AEMPTY_P = ptr_t'(AEMPTY_LVL);

    function automatic ptr_t bin2gray(input ptr_t b);
        return b ^ (b >> 1);
    endfunction

    function automatic ptr_t gray2bin(input ptr_t g);
        ptr_t b;
        b = g;
        for (int i = AW - 1; i >= 0; i--) b[i] = b[i+1] ^ g[i];
        return b;
    endfunction

    // Per-domain reset: asserts immediately, releases two edges after i_rst_n rises.
    logic [1:0] wrst_q;
    logic [1:0] rrst_q;
    logic       wrst_n;
    logic       rrst_n;

    // NOTE: every register update uses non-blocking assignment so all flops sample
    // pre-edge values; a blocking '=' here would turn a shift chain into one flop.
    always_ff @(posedge i_wclk or negedge i_rst_n) begin
        if (!i_rst_n) wrst_q <= 2'b00;
        else          wrst_q <= {wrst_q[0], 1'b1};
    end

    always_ff @(posedge i_rclk or negedge i_rst_n) begin
        if (!i_rst_n) rrst_q <= 2'b00;
        else          rrst_q <= {rrst_q[0], 1'b1};
    end

    assign wrst_n = wrst_q[1];
    assign rrst_n = rrst_q[1];

    logic [DATA_W:0] mem [DEPTH];

    // ---------------- write domain ----------------
    ptr_t w_ptr;
    ptr_t w_ptr_next;
    ptr_t w_gray;
    ptr_t r_gray;
    ptr_t rq [SYNC_STAGES];
    logic w_full;
    logic w_push;

    assign w_full     = (w_gray == {~rq[SYNC_STAGES-1][AW:AW-1], rq[SYNC_STAGES-1][AW-2:0]});
    assign s_tready   = wrst_n & ~w_full;
    assign w_push     = s_tvalid & s_tready;
    assign w_ptr_next = w_ptr + ptr_t'(w_push);

    always_ff @(posedge i_wclk or negedge wrst_n) begin
        if (!wrst_n) begin
            w_ptr    <= '0;
            w_gray   <= '0;
            o_wcount <= '0;
        end else begin
            w_ptr    <= w_ptr_next;
            w_gray   <= bin2gray(w_ptr_next);
            o_wcount <= w_ptr_next - gray2bin(rq[SYNC_STAGES-1]);
        end
    end

    always_ff @(posedge i_wclk or negedge wrst_n) begin
        if (!wrst_n) begin
            for (int i = 0; i < SYNC_STAGES; i++) rq[i] <= '0;
        end else begin
            rq[0] <= r_gray;
            for (int i = 1; i < SYNC_STAGES; i++) rq[i] <= rq[i-1];
        end
    end

    // NOTE: the storage array has no reset; pointers alone decide which entries
    // are valid, and a reset port would stop it mapping onto RAM.
    always_ff @(posedge i_wclk) begin
        if (w_push) mem[w_ptr[AW-1:0]] <= {s_tlast, s_tdata};
    end

    assign o_walmost_full = (o_wcount >= AFULL_P);

    // ---------------- read domain ----------------
    // f_ptr fetches into the output register; c_ptr counts words actually consumed,
    // so the word held in the output register keeps its entry reserved.
    ptr_t f_ptr;
    ptr_t f_ptr_next;
    ptr_t f_gray;
    ptr_t c_ptr;
    ptr_t c_ptr_next;
    ptr_t wq [SYNC_STAGES];
    logic ram_empty;
    logic r_load;
    logic r_pop;
    logic out_valid_next;

    // NOTE: each signal gets a value on every path through this block; leaving one
    // unassigned on some branch would infer a latch.
    always_comb begin
        ram_empty      = (f_gray == wq[SYNC_STAGES-1]);
        r_pop          = m_tvalid & m_tready;
        r_load         = ~ram_empty & (~m_tvalid | m_tready);
        out_valid_next = r_load | (m_tvalid & ~m_tready);
        f_ptr_next     = f_ptr + ptr_t'(r_load);
        c_ptr_next     = c_ptr + ptr_t'(r_pop);
    end

    always_ff @(posedge i_rclk or negedge rrst_n) begin
        if (!rrst_n) begin
            f_ptr    <= '0;
            f_gray   <= '0;
            c_ptr    <= '0;
            r_gray   <= '0;
            m_tvalid <= 1'b0;
            o_rcount <= '0;
        end else begin
            f_ptr    <= f_ptr_next;
            f_gray   <= bin2gray(f_ptr_next);
            c_ptr    <= c_ptr_next;
            r_gray   <= bin2gray(c_ptr_next);
            m_tvalid <= out_valid_next;
            o_rcount <= gray2bin(wq[SYNC_STAGES-1]) - f_ptr_next + ptr_t'(out_valid_next);
        end
    end

    always_ff @(posedge i_rclk or negedge rrst_n) begin
        if (!rrst_n) begin
            for (int i = 0; i < SYNC_STAGES; i++) wq[i] <= '0;
        end else begin
            wq[0] <= w_gray;
            for (int i = 1; i < SYNC_STAGES; i++) wq[i] <= wq[i-1];
        end
    end

    always_ff @(posedge i_rclk) begin
        if (r_load) {m_tlast, m_tdata} <= mem[f_ptr[AW-1:0]];
    end

    assign o_ralmost_empty = (o_rcount <= AEMPTY_P);

endmodule
